// File: rtl/iot_event_serialiser.sv
// rtl/iot_event_serialiser.sv - per-device join/leave tracker and round-robin event serialiser
//
// Collects one-cycle join/leave request pulses from N_DEV device ports, keeps
// the committed active state of every device, and emits at most one net state
// change per clock as a change/on_off/dev_id event for the monitor counter.
// A local mirror of the active-device count is kept for cross-checking.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset; release is synchronised internally
//   dev_join      bit i pulses: device i requests to become active
//   dev_leave     bit i pulses: device i requests to become inactive
//   change        one-cycle event strobe
//   on_off        event direction when change=1 (1 = join, 0 = leave)
//   dev_id        device index the current event refers to
//   active_map    committed active state per device
//   active_count  population count of active_map
//   pending       high while any device has an unserviced request

module iot_event_serialiser #(
    parameter int N_DEV = 8,
    parameter int IDW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_join,
    input  logic [N_DEV-1:0] dev_leave,
    output logic             change,
    output logic             on_off,
    output logic [IDW-1:0]   dev_id,
    output logic [N_DEV-1:0] active_map,
    output logic [7:0]       active_count,
    output logic             pending
);

    // Release synchroniser: the first edge after release only sets run_q,
    // so requests are first accepted on the second edge.
    logic run_q;

    logic [N_DEV-1:0] active_q, active_d;
    logic [N_DEV-1:0] pend_v_q, pend_v_d;
    logic [N_DEV-1:0] pend_dir_q, pend_dir_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic [IDW-1:0]   dev_id_q, dev_id_d;
    logic [7:0]       count_q, count_d;
    logic             pending_q, pending_d;

    // Arbitration results
    logic             grant;
    logic [IDW-1:0]   sel;
    logic [N_DEV-1:0] gnt_oh;
    logic             gdir;

    // Request capture intermediates
    logic [N_DEV-1:0] act_g;
    logic [N_DEV-1:0] pv_g;
    logic [N_DEV-1:0] eff;
    logic [N_DEV-1:0] req;
    logic [N_DEV-1:0] new_req;
    logic [N_DEV-1:0] cancel;
    logic [N_DEV-1:0] set_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Round-robin pick: the lowest pending index at or above the pointer wins;
    // otherwise wrap and take the lowest pending index below it. The loop runs
    // downward so the last hit in each half is the lowest index.
    always_comb begin
        logic           hi_found;
        logic           lo_found;
        logic [IDW-1:0] hi_sel;
        logic [IDW-1:0] lo_sel;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (pend_v_q[i]) begin
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_sel   = IDW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_sel   = IDW'(i);
                end
            end
        end
        grant = hi_found | lo_found;
        sel   = hi_found ? hi_sel : lo_sel;
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < N_DEV; i++) begin
            gnt_oh[i] = grant && (sel == IDW'(i));
        end
    end

    assign gdir = |(pend_dir_q & gnt_oh);

    // New requests are judged against the post-grant state, so a request on
    // the device being granted this edge sees its freshly committed value.
    always_comb begin
        act_g   = (active_q & ~gnt_oh) | (pend_dir_q & gnt_oh);
        pv_g    = pend_v_q & ~gnt_oh;
        eff     = (pv_g & pend_dir_q) | (~pv_g & act_g);
        // join and leave together on one device cancel out and are dropped
        req     = (dev_join ^ dev_leave) & {N_DEV{run_q}};
        // only requests that move a device away from its effective state count
        new_req = req & (dev_join ^ eff);
        // an opposite request on a pending device withdraws it silently
        cancel  = new_req & pv_g;
        set_req = new_req & ~pv_g;

        active_d   = act_g;
        pend_v_d   = (pv_g & ~cancel) | set_req;
        pend_dir_d = (pend_dir_q & ~set_req) | (dev_join & set_req);
    end

    always_comb begin
        change_d  = grant;
        on_off_d  = on_off_q;
        dev_id_d  = dev_id_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        if (grant) begin
            on_off_d = gdir;
            dev_id_d = sel;
            ptr_d    = (sel == IDW'(N_DEV - 1)) ? '0 : sel + IDW'(1);
            count_d  = gdir ? count_q + 8'd1 : count_q - 8'd1;
        end
        pending_d = |pend_v_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q   <= '0;
            pend_v_q   <= '0;
            pend_dir_q <= '0;
            ptr_q      <= '0;
            change_q   <= 1'b0;
            on_off_q   <= 1'b0;
            dev_id_q   <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
        end else begin
            active_q   <= active_d;
            pend_v_q   <= pend_v_d;
            pend_dir_q <= pend_dir_d;
            ptr_q      <= ptr_d;
            change_q   <= change_d;
            on_off_q   <= on_off_d;
            dev_id_q   <= dev_id_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
        end
    end

    assign change       = change_q;
    assign on_off       = on_off_q;
    assign dev_id       = dev_id_q;
    assign active_map   = active_q;
    assign active_count = count_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_iot_event_serialiser.sv
// tb/tb_iot_event_serialiser.sv - scoreboard bench for iot_event_serialiser
module tb_iot_event_serialiser;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] dev_join;
    logic [N-1:0] dev_leave;
    logic         change;
    logic         on_off;
    logic [W-1:0] dev_id;
    logic [N-1:0] active_map;
    logic [7:0]   active_count;
    logic         pending;

    iot_event_serialiser #(.N_DEV(N), .IDW(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .dev_join     (dev_join),
        .dev_leave    (dev_leave),
        .change       (change),
        .on_off       (on_off),
        .dev_id       (dev_id),
        .active_map   (active_map),
        .active_count (active_count),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit dir;
        int id;
        int cnt;
    } evt_t;

    evt_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    bit m_act[N];
    bit m_pv[N];
    bit m_dir[N];
    int m_ptr;
    bit m_en;

    // Monitor-counter stand-in and its pending check
    int mon_cnt;
    bit mon_chk;
    int mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_act[i]);
        return c;
    endfunction

    function automatic logic [N-1:0] m_map();
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) m[i] = m_act[i];
        return m;
    endfunction

    function automatic bit m_any();
        bit a = 1'b0;
        for (int i = 0; i < N; i++) a |= m_pv[i];
        return a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 1'b0;
            m_pv[i]  = 1'b0;
            m_dir[i] = 1'b0;
        end
        m_ptr   = 0;
        m_en    = 1'b0;
        mon_chk = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the serialiser's rules: grant first, then requests
    // judged against the post-grant state.
    task automatic model_edge(input logic [N-1:0] j, input logic [N-1:0] l);
        int   sel = -1;
        evt_t e;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (sel < 0 && m_pv[idx]) sel = idx;
        end
        if (sel >= 0) begin
            m_act[sel] = m_dir[sel];
            m_pv[sel]  = 1'b0;
            m_ptr      = (sel + 1) % N;
            e.dir = m_dir[sel];
            e.id  = sel;
            e.cnt = m_count();
            exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            if (j[i] != l[i]) begin
                bit want = j[i];
                bit eff  = m_pv[i] ? m_dir[i] : m_act[i];
                if (want != eff) begin
                    if (m_pv[i]) begin
                        m_pv[i] = 1'b0;
                    end else begin
                        m_pv[i]  = 1'b1;
                        m_dir[i] = want;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] j, input logic [N-1:0] l);
        dev_join  = j;
        dev_leave = l;
        @(posedge clk);
        if (rst) begin
            if (m_en) model_edge(j, l);
            m_en = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        model_clear();
        repeat (n) cycle('0, '0);
        rst = 1'b1;
        repeat (3) cycle('0, '0);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) mon_cnt <= 0;
        else if (change) mon_cnt <= on_off ? mon_cnt + 1 : mon_cnt - 1;
    end

    always @(negedge clk) begin : monitor
        evt_t e;
        if (mon_chk) check("monitor_counter", mon_cnt, mon_exp);
        mon_chk = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("evt_change", change, 1);
            check("evt_on_off", on_off, e.dir);
            check("evt_dev_id", dev_id, e.id);
            mon_chk = 1'b1;
            mon_exp = e.cnt;
        end else begin
            check("idle_change", change, 0);
        end
        check("active_map", active_map, m_map());
        check("active_count", active_count, m_count());
        check("pending", pending, m_any());
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        dev_join  = '0;
        dev_leave = '0;
        rst       = 1'b1;
        model_clear();
        #1 rst = 1'b0;

        // Reset held with random requests: everything stays zero
        for (int c = 0; c < 10; c++) begin
            cycle(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
            check("reset_outputs", {change, on_off, dev_id, active_map, active_count, pending}, 0);
        end
        rst = 1'b1;
        // First edge after release must not accept a request
        cycle(4'b0001, '0);
        repeat (10) cycle('0, '0);
        check("sync_first_edge_ignored", active_map, 0);

        // Single join
        cycle(4'b0100, '0);
        @(negedge clk);
        check("single_pending", pending, 1);
        check("single_no_early_change", change, 0);
        cycle('0, '0);
        @(negedge clk);
        check("single_change", change, 1);
        check("single_on_off", on_off, 1);
        check("single_dev_id", dev_id, 2);
        repeat (2) cycle('0, '0);
        check("single_map", active_map, 4'b0100);
        check("single_count", active_count, 1);

        // Burst and round-robin order
        do_reset(3);
        cycle(4'b1111, '0);
        for (int k = 0; k < N; k++) begin
            cycle('0, '0);
            @(negedge clk);
            check("burst_change", change, 1);
            check("burst_on_off", on_off, 1);
            check("burst_dev_id", dev_id, k);
        end
        repeat (2) cycle('0, '0);
        check("burst_count", active_count, 4);

        // Cancel while the arbiter is busy, then duplicate, then join+leave together
        cycle('0, 4'b1011);
        cycle(4'b0010, '0);
        repeat (5) cycle('0, '0);
        check("cancel_map", active_map, 4'b0110);
        check("cancel_count", active_count, 2);
        cycle(4'b0010, '0);
        repeat (3) cycle('0, '0);
        check("dup_map", active_map, 4'b0110);
        cycle(4'b1000, 4'b1000);
        repeat (3) cycle('0, '0);
        check("both_map", active_map, 4'b0110);
        check("both_count", active_count, 2);

        // Random join/leave traffic against the model and monitor counter
        for (int c = 0; c < 200; c++) begin
            cycle(N'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  N'($urandom_range(0, 15) & $urandom_range(0, 15)));
        end
        repeat (8) cycle('0, '0);
        check("drain_pending", pending, 0);

        // Reset mid-burst
        do_reset(2);
        cycle(4'b1111, '0);
        cycle('0, '0);
        cycle('0, '0);
        @(negedge clk);
        #1;
        check("midburst_count_before", active_count, 2);
        rst = 1'b0;
        model_clear();
        #1;
        check("midburst_change", change, 0);
        check("midburst_count", active_count, 0);
        check("midburst_pending", pending, 0);
        check("midburst_map", active_map, 0);
        repeat (3) cycle('0, '0);
        rst = 1'b1;
        repeat (5) cycle('0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iot_event_serialiser.md
Name: iot_event_serialiser

Overview:
- Front end of the Active IoT Devices Monitor.
- Collects per-device join/leave request pulses from N_DEV device ports and tracks the active/inactive state of each device.
- Serialises net state changes into at most one change/on_off event per clock, in the form the monitor counter consumes (change=1 with on_off=1 counts up; on_off=0 counts down).
- Keeps a local mirror of the active-device count for cross-checking against the monitor's counter_out.

Parameters:
- N_DEV, 8, number of device request ports (2..255).
- IDW, 3, width of dev_id; must satisfy 2**IDW >= N_DEV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- dev_join  input  N_DEV  bit i high for one cycle = device i requests to become active.
- dev_leave  input  N_DEV  bit i high for one cycle = device i requests to become inactive.
- change  output  1  one-cycle event strobe to the monitor.
- on_off  output  1  event direction, valid when change=1: 1 = join, 0 = leave.
- dev_id  output  IDW  index of the device the current event refers to.
- active_map  output  N_DEV  committed active state per device.
- active_count  output  8  population count of active_map.
- pending  output  1  high while any device has an unserviced request.

Behaviour:
- Reset (rst=0, asynchronous): change=0, on_off=0, dev_id=0, active_map=0, active_count=0, pending=0, all internal pend flags cleared, round-robin pointer=0. Rising edge of rst is synchronised internally; the first request is accepted on the second clock edge after release.
- Per-device state: active[i]; pend_v[i]; pend_dir[i].
- Effective state eff[i] = pend_v[i] ? pend_dir[i] : active[i].
- Request capture, evaluated per device at each rising edge:
  - join and leave both high on the same device: ignored.
  - Requested direction equals eff[i]: ignored (duplicate).
  - Otherwise, if pend_v[i]=1: pend_v[i] is cleared (the opposite request cancels; no event is ever emitted for it).
  - Otherwise: pend_v[i]=1, pend_dir[i]=requested direction.
- Arbitration, each edge:
  - If any pend_v is set, select the first set index starting at the pointer, scanning upward with wrap at N_DEV-1 -> 0.
  - On the next cycle: change=1, on_off=pend_dir[sel], dev_id=sel.
  - In the same edge: active[sel] is updated, pend_v[sel] is cleared, and the pointer is set to (sel+1) mod N_DEV.
  - If no pend_v is set: change=0; on_off and dev_id hold their previous values.
- A request on the device being granted in the same edge is evaluated against the post-grant state. The eff rule already gives this result.
- Latency: a request sampled at edge t sets pend at edge t. The earliest possible change strobe is registered at edge t+1.
- Throughput and fairness: at most one event per cycle. Under saturation each device with a pending request is serviced within N_DEV cycles.
- active_count updates in the same edge as active_map (+1 on join grant, -1 on leave grant). It cannot wrap because it is bounded by N_DEV.
- pending is the registered OR of pend_v after the edge update.
- Reset mid-operation discards all pending requests and committed state. The monitor must be reset alongside.

Test Plan (N_DEV=4):
- Reset: hold rst=0 for 10 cycles with random requests -> all outputs 0. Release rst, idle 10 cycles -> change never asserted.
- Single join: dev_join=4'b0100 for one cycle -> exactly one change pulse 1 cycle later with on_off=1, dev_id=2. Then active_map=4'b0100 and active_count=1.
- Burst and round-robin: dev_join=4'b1111 in one cycle -> four consecutive change pulses with dev_id 0,1,2,3, all on_off=1. Final active_count=4.
- Cancel and duplicate:
  - With device 1 active, assert dev_leave[1] while the arbiter is busy, then dev_join[1] before it is granted -> no event for device 1; active_map unchanged.
  - dev_join[1] again -> ignored, no event.
- Simultaneous join and leave: dev_join[3]=dev_leave[3]=1 in the same cycle -> no event, state unchanged.
- Reset mid-burst: assert dev_join=4'b1111 and drop rst after 2 events -> immediately change=0, active_count=0, pending=0.
- Monitor cross-check: connect to the monitor, run a random join/leave sequence of 200 cycles -> monitor counter_out equals active_count one cycle after each event.
